cb_rd_arbiter: RTL and testbench
================================

Name: cb_rd_arbiter

Overview:
- Shares one core-bus read channel (AR/R, single-beat, in-order) between two requesters: M0 = instruction fetch, M1 = LSU read path.
- Sits between the fetch/LSU core-bus masters and the single core-bus-to-AXI bridge, for single-port memory configurations.
- AR requests are arbitrated round-robin. Grant order is recorded in an order FIFO, and in-order R responses are steered back to the owning requester.
- LSU write channels do not pass through this block.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read data width
MAX_OUT, 4, max outstanding reads (order FIFO depth, power of two, >=2)

Ports:
clk  in  1  core clock
arst  in  1  asynchronous reset, active-low
m0_ar_valid  in  1  M0 read request valid
m0_ar_ready  out  1  M0 read request accepted
m0_ar_addr  in  ADDR_W  M0 read address
m0_r_valid  out  1  M0 read data valid
m0_r_ready  in  1  M0 read data accept
m0_r_data  out  DATA_W  M0 read data
m0_r_resp  out  2  M0 response code
m1_ar_valid / m1_ar_ready / m1_ar_addr / m1_r_valid / m1_r_ready / m1_r_data / m1_r_resp  same as M0, for M1
s_ar_valid  out  1  shared request valid
s_ar_ready  in  1  shared request accept
s_ar_addr  out  ADDR_W  shared address
s_r_valid  in  1  shared response valid
s_r_ready  out  1  shared response accept
s_r_data  in  DATA_W  shared data
s_r_resp  in  2  shared response code
outstanding_o  out  clog2(MAX_OUT)+1  entries in order FIFO
unexp_r_o  out  1  one-cycle pulse: s_r_valid while FIFO empty

Behaviour:
- Reset (arst=0, async assert, sync release): FIFO pointers and count = 0, lock = 0, last_grant = M1 (M0 wins the first tie), unexp_r_o = 0. All valid/ready outputs are combinational and are 0 while the FIFO is empty and no request is present.
- Arbitration, when unlocked:
  - Exactly one requester valid: grant it.
  - Both valid: grant the requester that is not last_grant.
- Lock: if s_ar_valid=1 and s_ar_ready=0, set lock and hold the current grant until the handshake completes. AR addr/valid must stay stable (AXI rule).
- s_ar_valid = granted requester's ar_valid & !full. s_ar_addr = granted requester's addr, with zero latency (combinational mux).
- mX_ar_ready = s_ar_ready & !full & (grant==X). Non-granted requester sees ready=0.
- On an AR handshake: push the grant ID (1 bit) into the FIFO, update last_grant, clear lock.
- full (count==MAX_OUT): s_ar_valid forced 0. A pop in the same cycle does not make room that cycle (no full-bypass); the request issues the next cycle.
- R routing, head = FIFO head ID:
  - mX_r_valid = s_r_valid & !empty & (head==X).
  - mX_r_data/resp = s_r_data/resp when head==X, else 0.
  - s_r_ready = !empty & head requester's r_ready.
  - Pop on s_r_valid & s_r_ready.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo MAX_OUT.
- Empty FIFO and s_r_valid=1: s_r_ready=0, no requester valid, unexp_r_o pulses 1 for that cycle (registered, visible next cycle).
- Error responses (resp!=0) are routed unchanged; the arbiter does not act on them.
- Reset mid-transaction: FIFO is flushed. Late R beats arriving after reset raise unexp_r_o. Upstream is reset together with the arbiter.
- outstanding_o = count, registered.

Test Plan:
- Single M0 read: m0_ar addr 0x8000_0000, s_ar_ready=1, then s_r data 0xDEAD_BEEF resp 0 → s_ar_addr=0x8000_0000 the same cycle; m0_r_data=0xDEAD_BEEF; m1_r_valid=0; outstanding 1→0.
- Tie after reset: M0 and M1 valid in the same cycle → M0 granted first, M1 on the next handshake. Responses 0x11, 0x22 go to M0 then M1, in order.
- Stall lock: both valid, s_ar_ready=0 for 3 cycles → grant held on M0 and s_ar_addr stable; M1 is granted after M0 is accepted.
- Full: MAX_OUT=4, 4 AR accepted with no R → outstanding_o=4 and s_ar_valid=0. One R pop → s_ar_valid=1 the following cycle.
- Back-pressure: head=M1, m1_r_ready=0 for 2 cycles → s_r_ready=0 and data is held. Meanwhile an M0 AR is accepted in parallel, so push and pop are concurrent once ready rises.
- Unexpected R: FIFO empty, s_r_valid=1 → unexp_r_o=1 for one cycle; no mX_r_valid. Then arst=0 mid-transaction → outstanding_o=0 immediately.

Source files
------------

// File: rtl/cb_rd_arbiter.sv
// cb_rd_arbiter: shares one single-beat, in-order core-bus read channel
// between instruction fetch (M0) and the LSU read path (M1).
//
// Ports:
//   clk, arst               core clock, async active-low reset
//   m0_ar_* / m1_ar_*       requester AR channels (valid/ready/addr)
//   m0_r_*  / m1_r_*        requester R channels (valid/ready/data/resp)
//   s_ar_*                  shared AR channel towards the AXI bridge
//   s_r_*                   shared R channel from the AXI bridge
//   outstanding_o           registered count of reads awaiting response
//   unexp_r_o               registered pulse: R beat seen with no read outstanding
//
// AR requests are arbitrated round-robin. Each accepted AR pushes its owner ID
// into an order FIFO, and the FIFO head steers the in-order R beats back.
module cb_rd_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                       clk,
    input  logic                       arst,

    input  logic                       m0_ar_valid,
    output logic                       m0_ar_ready,
    input  logic [ADDR_W-1:0]          m0_ar_addr,
    output logic                       m0_r_valid,
    input  logic                       m0_r_ready,
    output logic [DATA_W-1:0]          m0_r_data,
    output logic [1:0]                 m0_r_resp,

    input  logic                       m1_ar_valid,
    output logic                       m1_ar_ready,
    input  logic [ADDR_W-1:0]          m1_ar_addr,
    output logic                       m1_r_valid,
    input  logic                       m1_r_ready,
    output logic [DATA_W-1:0]          m1_r_data,
    output logic [1:0]                 m1_r_resp,

    output logic                       s_ar_valid,
    input  logic                       s_ar_ready,
    output logic [ADDR_W-1:0]          s_ar_addr,
    input  logic                       s_r_valid,
    output logic                       s_r_ready,
    input  logic [DATA_W-1:0]          s_r_data,
    input  logic [1:0]                 s_r_resp,

    output logic [$clog2(MAX_OUT):0]   outstanding_o,
    output logic                       unexp_r_o
);

    localparam int unsigned PTR_W = $clog2(MAX_OUT);
    localparam int unsigned CNT_W = PTR_W + 1;

    // OPEN: grant follows round-robin; LOCKED: grant frozen while AR is stalled
    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    arb_state_e         state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_q, last_d;
    logic [MAX_OUT-1:0] ids_q, ids_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               unexp_q, unexp_d;

    logic               pick;
    logic               grant_c;
    logic               full;
    logic               empty;
    logic               head;
    logic               ar_hs;
    logic               r_hs;

    assign full  = (count_q == CNT_W'(MAX_OUT));
    assign empty = (count_q == '0);
    assign head  = ids_q[rd_ptr_q];

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        pick = ~last_q;
        if (m0_ar_valid && !m1_ar_valid) begin
            pick = 1'b0;
        end else if (m1_ar_valid && !m0_ar_valid) begin
            pick = 1'b1;
        end
    end

    assign grant_c = (state_q == ARB_LOCKED) ? grant_q : pick;

    // Shared AR mux; no new request is offered while the order FIFO is full
    assign s_ar_valid  = (grant_c ? m1_ar_valid : m0_ar_valid) & ~full;
    assign s_ar_addr   = grant_c ? m1_ar_addr : m0_ar_addr;
    assign m0_ar_ready = s_ar_ready & ~full & ~grant_c;
    assign m1_ar_ready = s_ar_ready & ~full &  grant_c;
    assign ar_hs       = s_ar_valid & s_ar_ready;

    // R steering by FIFO head owner
    assign m0_r_valid = s_r_valid & ~empty & ~head;
    assign m1_r_valid = s_r_valid & ~empty &  head;
    assign m0_r_data  = head ? '0 : s_r_data;
    assign m0_r_resp  = head ? 2'b00 : s_r_resp;
    assign m1_r_data  = head ? s_r_data : '0;
    assign m1_r_resp  = head ? s_r_resp : 2'b00;
    assign s_r_ready  = ~empty & (head ? m1_r_ready : m0_r_ready);
    assign r_hs       = s_r_valid & s_r_ready;

    assign outstanding_o = count_q;
    assign unexp_r_o     = unexp_q;

    // Arbiter lock state register
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= ARB_OPEN;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Arbiter lock next-state: freeze grant on a stalled AR, release on handshake
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (ar_hs) begin
            last_d = grant_c;
        end
        case (state_q)
            ARB_OPEN: begin
                if (s_ar_valid && !s_ar_ready) begin
                    state_d = ARB_LOCKED;
                    grant_d = grant_c;
                end
            end
            ARB_LOCKED: begin
                if (ar_hs) begin
                    state_d = ARB_OPEN;
                end
            end
            default: begin
                state_d = ARB_OPEN;
            end
        endcase
    end

    // Order FIFO next-state: push owner on AR handshake, pop on R handshake
    always_comb begin
        ids_d    = ids_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(ar_hs) - CNT_W'(r_hs);
        unexp_d  = s_r_valid & empty;
        if (ar_hs) begin
            ids_d[wr_ptr_q] = grant_c;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (r_hs) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // Order FIFO registers
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            ids_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            unexp_q  <= 1'b0;
        end else begin
            ids_q    <= ids_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            unexp_q  <= unexp_d;
        end
    end

endmodule

// File: tb/tb_cb_rd_arbiter.sv
// Bench for cb_rd_arbiter: expected R owners are queued as ARs are issued and
// checked against the steering outputs as each R beat is presented.
module tb_cb_rd_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAX_OUT = 4;

    logic              clk = 1'b0;
    logic              arst;
    logic              m0_ar_valid, m0_ar_ready, m0_r_valid, m0_r_ready;
    logic [ADDR_W-1:0] m0_ar_addr;
    logic [DATA_W-1:0] m0_r_data;
    logic [1:0]        m0_r_resp;
    logic              m1_ar_valid, m1_ar_ready, m1_r_valid, m1_r_ready;
    logic [ADDR_W-1:0] m1_ar_addr;
    logic [DATA_W-1:0] m1_r_data;
    logic [1:0]        m1_r_resp;
    logic              s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
    logic [ADDR_W-1:0] s_ar_addr;
    logic [DATA_W-1:0] s_r_data;
    logic [1:0]        s_r_resp;
    logic [2:0]        outstanding_o;
    logic              unexp_r_o;

    int n_chk  = 0;
    int n_pass = 0;
    bit sb_q[$];

    cb_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .arst(arst),
        .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready), .m0_ar_addr(m0_ar_addr),
        .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready), .m0_r_data(m0_r_data), .m0_r_resp(m0_r_resp),
        .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready), .m1_ar_addr(m1_ar_addr),
        .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready), .m1_r_data(m1_r_data), .m1_r_resp(m1_r_resp),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
        .outstanding_o(outstanding_o), .unexp_r_o(unexp_r_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check R steering for a beat owned by o
    task automatic r_check(input bit o, input logic [31:0] d, input logic [1:0] rsp);
        chk("m0_r_valid", m0_r_valid, o == 1'b0);
        chk("m1_r_valid", m1_r_valid, o == 1'b1);
        chk("r_data", o ? m1_r_data : m0_r_data, d);
        chk("r_data_other", o ? m0_r_data : m1_r_data, 0);
        chk("r_resp", o ? m1_r_resp : m0_r_resp, rsp);
        chk("s_r_ready", s_r_ready, o ? m1_r_ready : m0_r_ready);
    endtask

    task automatic r_present(input logic [31:0] d, input logic [1:0] rsp);
        s_r_valid = 1'b1;
        s_r_data  = d;
        s_r_resp  = rsp;
        #1;
        if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL sb_underflow: R beat with no expected owner queued");
        end else begin
            r_check(sb_q.pop_front(), d, rsp);
        end
    endtask

    task automatic r_beat(input logic [31:0] d, input logic [1:0] rsp);
        m0_r_ready = 1'b1;
        m1_r_ready = 1'b1;
        r_present(d, rsp);
        step();
        s_r_valid = 1'b0;
    endtask

    task automatic do_reset();
        arst = 1'b0;
        sb_q.delete();
        step();
        step();
        arst = 1'b1;
        step();
    endtask

    initial begin
        arst = 1'b0;
        m0_ar_valid = 0; m0_ar_addr = '0; m0_r_ready = 0;
        m1_ar_valid = 0; m1_ar_addr = '0; m1_r_ready = 0;
        s_ar_ready = 0; s_r_valid = 0; s_r_data = '0; s_r_resp = '0;
        step();
        step();
        chk("rst_s_ar_valid", s_ar_valid, 0);
        chk("rst_s_r_ready", s_r_ready, 0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_unexp", unexp_r_o, 0);
        chk("rst_m0_r_valid", m0_r_valid, 0);
        arst = 1'b1;
        step();

        // Single M0 read
        m0_ar_valid = 1; m0_ar_addr = 32'h8000_0000; s_ar_ready = 1;
        #1;
        chk("s1_s_ar_valid", s_ar_valid, 1);
        chk("s1_s_ar_addr", s_ar_addr, 32'h8000_0000);
        chk("s1_m0_ar_ready", m0_ar_ready, 1);
        chk("s1_m1_ar_ready", m1_ar_ready, 0);
        sb_q.push_back(1'b0);
        step();
        m0_ar_valid = 0;
        #1;
        chk("s1_outstanding1", outstanding_o, 1);
        r_beat(32'hDEAD_BEEF, 2'd0);
        #1;
        chk("s1_outstanding0", outstanding_o, 0);

        // Tie after reset: M0 first, then M1
        do_reset();
        m0_ar_valid = 1; m0_ar_addr = 32'h0000_1000;
        m1_ar_valid = 1; m1_ar_addr = 32'h0000_2000;
        s_ar_ready = 1;
        #1;
        chk("tie_m0_ready", m0_ar_ready, 1);
        chk("tie_m1_ready", m1_ar_ready, 0);
        chk("tie_addr0", s_ar_addr, 32'h0000_1000);
        sb_q.push_back(1'b0);
        step();
        m0_ar_valid = 0;
        #1;
        chk("tie_m1_ready2", m1_ar_ready, 1);
        chk("tie_addr1", s_ar_addr, 32'h0000_2000);
        sb_q.push_back(1'b1);
        step();
        m1_ar_valid = 0;
        #1;
        chk("tie_outstanding", outstanding_o, 2);
        r_beat(32'h11, 2'd0);
        r_beat(32'h22, 2'd0);

        // Stall lock with both valid: M0 held, then M1
        m0_ar_valid = 1; m0_ar_addr = 32'h0000_3000;
        m1_ar_valid = 1; m1_ar_addr = 32'h0000_4000;
        s_ar_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_valid", s_ar_valid, 1);
            chk("stall_addr", s_ar_addr, 32'h0000_3000);
            chk("stall_m0_ready", m0_ar_ready, 0);
            step();
        end
        s_ar_ready = 1;
        #1;
        chk("stall_m0_accept", m0_ar_ready, 1);
        sb_q.push_back(1'b0);
        step();
        m0_ar_valid = 0;
        #1;
        chk("stall_m1_addr", s_ar_addr, 32'h0000_4000);
        chk("stall_m1_accept", m1_ar_ready, 1);
        sb_q.push_back(1'b1);
        step();
        m1_ar_valid = 0;
        r_beat(32'h33, 2'd0);
        r_beat(32'h44, 2'd0);

        // Lock holds M1 even when M0 (the tie favourite) shows up mid-stall
        m1_ar_valid = 1; m1_ar_addr = 32'h0000_5000; s_ar_ready = 0;
        #1;
        chk("lock_addr_m1", s_ar_addr, 32'h0000_5000);
        step();
        m0_ar_valid = 1; m0_ar_addr = 32'h0000_6000;
        #1;
        chk("lock_hold_addr", s_ar_addr, 32'h0000_5000);
        s_ar_ready = 1;
        #1;
        chk("lock_m1_ready", m1_ar_ready, 1);
        chk("lock_m0_ready", m0_ar_ready, 0);
        sb_q.push_back(1'b1);
        step();
        m1_ar_valid = 0;
        #1;
        chk("lock_then_m0", m0_ar_ready, 1);
        sb_q.push_back(1'b0);
        step();
        m0_ar_valid = 0;
        r_beat(32'h55, 2'd0);
        r_beat(32'h66, 2'd1);

        // Full FIFO, no bypass on the pop cycle
        m0_ar_valid = 1; s_ar_ready = 1;
        for (int i = 0; i < 4; i++) begin
            m0_ar_addr = 32'h0001_0000 + 32'(i * 4);
            #1;
            chk("full_fill_ready", m0_ar_ready, 1);
            sb_q.push_back(1'b0);
            step();
        end
        #1;
        chk("full_outstanding", outstanding_o, 4);
        chk("full_s_ar_valid", s_ar_valid, 0);
        chk("full_m0_ready", m0_ar_ready, 0);
        m0_r_ready = 1; m1_r_ready = 1;
        r_present(32'hA0, 2'd0);
        chk("full_no_bypass", s_ar_valid, 0);
        step();
        s_r_valid = 0;
        #1;
        chk("full_reissue_valid", s_ar_valid, 1);
        chk("full_reissue_ready", m0_ar_ready, 1);
        sb_q.push_back(1'b0);
        step();
        m0_ar_valid = 0;
        #1;
        chk("full_outstanding2", outstanding_o, 4);
        r_beat(32'hA1, 2'd0);
        r_beat(32'hA2, 2'd0);
        r_beat(32'hA3, 2'd0);
        r_beat(32'hA4, 2'd0);
        #1;
        chk("full_drained", outstanding_o, 0);

        // Back-pressure on M1 head with concurrent M0 AR
        m1_ar_valid = 1; m1_ar_addr = 32'h0002_0000; s_ar_ready = 1;
        #1;
        chk("bp_m1_ready", m1_ar_ready, 1);
        sb_q.push_back(1'b1);
        step();
        m1_ar_valid = 0;
        m0_r_ready = 1; m1_r_ready = 0;
        s_r_valid = 1; s_r_data = 32'h0000_0055; s_r_resp = 2'd2;
        m0_ar_valid = 1; m0_ar_addr = 32'h0002_0010;
        #1;
        r_check(sb_q[0], 32'h0000_0055, 2'd2);
        chk("bp_m0_ar_ready", m0_ar_ready, 1);
        sb_q.push_back(1'b0);
        step();
        m0_ar_valid = 0;
        #1;
        r_check(sb_q[0], 32'h0000_0055, 2'd2);
        chk("bp_outstanding", outstanding_o, 2);
        step();
        m1_r_ready = 1;
        m0_ar_valid = 1; m0_ar_addr = 32'h0002_0020;
        #1;
        r_check(sb_q.pop_front(), 32'h0000_0055, 2'd2);
        chk("bp_concurrent_ar", m0_ar_ready, 1);
        sb_q.push_back(1'b0);
        step();
        m0_ar_valid = 0; s_r_valid = 0;
        #1;
        chk("bp_outstanding2", outstanding_o, 2);
        r_beat(32'h77, 2'd0);
        r_beat(32'h88, 2'd3);

        // Unexpected R on empty FIFO
        m0_r_ready = 1; m1_r_ready = 1;
        s_r_valid = 1; s_r_data = 32'h99;
        #1;
        chk("unexp_m0_valid", m0_r_valid, 0);
        chk("unexp_m1_valid", m1_r_valid, 0);
        chk("unexp_s_r_ready", s_r_ready, 0);
        chk("unexp_not_yet", unexp_r_o, 0);
        step();
        s_r_valid = 0;
        #1;
        chk("unexp_pulse", unexp_r_o, 1);
        step();
        chk("unexp_clear", unexp_r_o, 0);

        // Reset mid-transaction flushes the FIFO; a late beat is unexpected
        m0_ar_valid = 1; m0_ar_addr = 32'h0003_0000; s_ar_ready = 1;
        step();
        m0_ar_valid = 0;
        #1;
        chk("mid_outstanding", outstanding_o, 1);
        arst = 1'b0;
        sb_q.delete();
        #1;
        chk("mid_rst_outstanding", outstanding_o, 0);
        step();
        arst = 1'b1;
        s_r_valid = 1; s_r_data = 32'hBB;
        #1;
        chk("late_m0_valid", m0_r_valid, 0);
        step();
        s_r_valid = 0;
        #1;
        chk("late_unexp", unexp_r_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
